// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receive stream block.
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } t_i2s_rx_state;

    localparam int c_sample_bits = 16;
    localparam int c_ovf_max     = 255;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush; head entry is visible
// on head_data whenever the FIFO is not empty (zero when empty).
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot the push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_rx_stream.sv
// I2S receiver: oversampled bclk/lrclk/sdata, stereo 16-bit frame assembly,
// FWFT buffering to a ready/valid stream. Macro I2S_RX_OVF_COUNT_EN enables ovf_count.
module i2s_rx_stream
    import i2s_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        i2s_bclk,
    input  logic        i2s_lrclk,
    input  logic        i2s_sdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        ovf_clear,
    output logic [7:0]  ovf_count
);

    localparam logic [4:0] SAMPLE_BITS = 5'(c_sample_bits);

    // Places bit b at the next MSB-first slot so short words end up left-aligned.
    function automatic logic [15:0] insert_bit(input logic [15:0] sr,
                                               input logic [4:0]  cnt,
                                               input logic        b);
        logic [15:0] r;
        r = sr;
        if (cnt < SAMPLE_BITS) begin
            r[4'(c_sample_bits - 1) - cnt[3:0]] = b;
        end
        return r;
    endfunction

    function automatic logic [4:0] bump_cnt(input logic [4:0] cnt);
        return (cnt < SAMPLE_BITS) ? cnt + 5'd1 : cnt;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'(c_ovf_max)) ? cnt : cnt + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_prev;
    logic                   bclk_s;
    logic                   lr_s;
    logic                   sd_s;
    logic                   bedge;

    t_i2s_rx_state state;
    logic [4:0]    bitcnt;
    logic [15:0]   left_sr;
    logic [15:0]   right_sr;
    logic [15:0]   right_nxt;
    logic          lr_prev;
    logic          rise_b;
    logic          fall_b;

    logic          frame_vld_p0;
    logic [31:0]   frame_p0;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;

    // Stage: input synchronisers and bclk rising-edge detect.
    always_ff @(posedge clock) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign bedge     = bclk_s && !bclk_prev;
    assign rise_b    = !lr_prev && lr_s;
    assign fall_b    = lr_prev && !lr_s;
    assign right_nxt = insert_bit(right_sr, bitcnt, sd_s);

    // Stage p0: word assembly; the boundary bit is the outgoing word's LSB.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state        <= SYNC;
            bitcnt       <= '0;
            left_sr      <= '0;
            right_sr     <= '0;
            lr_prev      <= 1'b0;
            frame_vld_p0 <= 1'b0;
            frame_p0     <= '0;
        end else begin
            frame_vld_p0 <= 1'b0;
            if (bedge) begin
                lr_prev <= lr_s;
                case (state)
                    SYNC: begin
                        if (fall_b) begin
                            state   <= LEFT;
                            bitcnt  <= '0;
                            left_sr <= '0;
                        end
                    end
                    LEFT: begin
                        if (fall_b) begin
                            state <= SYNC;
                        end else begin
                            left_sr <= insert_bit(left_sr, bitcnt, sd_s);
                            if (rise_b) begin
                                state    <= RIGHT;
                                bitcnt   <= '0;
                                right_sr <= '0;
                            end else begin
                                bitcnt <= bump_cnt(bitcnt);
                            end
                        end
                    end
                    RIGHT: begin
                        if (rise_b) begin
                            state <= SYNC;
                        end else if (fall_b) begin
                            frame_vld_p0 <= 1'b1;
                            frame_p0     <= {left_sr, right_nxt};
                            state        <= LEFT;
                            bitcnt       <= '0;
                            left_sr      <= '0;
                        end else begin
                            right_sr <= right_nxt;
                            bitcnt   <= bump_cnt(bitcnt);
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    assign pop  = out_valid && out_ready;
    assign drop = frame_vld_p0 && enable && fifo_full && !pop;

    // Stage p1: frame buffer; out_valid follows the write by one clock.
    sync_fifo_fwft #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (!enable),
        .push      (frame_vld_p0),
        .push_data (frame_p0),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;

`ifdef I2S_RX_OVF_COUNT_EN
    logic [7:0] ovf_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_cnt <= '0;
        end else if (ovf_clear) begin
            ovf_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

    assign ovf_count = ovf_cnt;
`else
    logic unused_ovf;

    assign unused_ovf = ovf_clear ^ drop ^ (^sat_inc(8'd0));
    assign ovf_count  = '0;
`endif

endmodule
